ksa_param: RTL and testbench



---
 rtl/ksa_param.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ksa_param.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_param.sv
// -----------------------------------------------------------------------------
// ksa_param -- parametrised RC4 key-scheduling engine
//
// Runs the 256-iteration RC4 KSA swap loop
//   j = j + S[i] + key[i mod KEY_BYTES];  swap S[i], S[j]
// against an external single-port 256x8 S-memory. An optional identity-fill
// pass (S[k] = k) can run first in the same invocation. Sits between the
// top-level controller and the S-memory, ahead of the PRGA stage.
//
// Parameters
//   KEY_BYTES  key length in bytes, 1..32
//   RD_LAT     S-memory read latency in cycles, 1..3
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   start request, honoured only while rdy=1
//   fill     in   sampled with en; 1 = identity-fill S before the KSA loop
//   key      in   key, byte 0 in the top byte (MSB-first)
//   rdy      out  idle and able to accept en
//   done     out  single-cycle completion pulse (coincides with first idle cycle)
//   addr     out  S-memory address
//   rddata   in   S-memory read data
//   wrdata   out  S-memory write data
//   wren     out  S-memory write enable
//   state_o  out  current FSM state, for debug and checkers
//
// Handshake: en/rdy. A run starts on any rising edge where rdy=1 and en=1;
// rdy is low from the following cycle until the done cycle, during which
// en/key/fill are ignored. The done cycle itself has rdy=1, so a request
// present then starts the next run immediately.
//
// Memory read contract: addr is held for RD_LAT+1 cycles; the memory
// captures addr at the end of the first of those cycles and the engine
// samples rddata at the end of the last one.
//
// All outputs come straight from registers: the combinational block below
// computes next-cycle output values alongside the next state.
// -----------------------------------------------------------------------------
module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   fill,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   rdy,
  output logic                   done,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_RD_I   = 3'd2,
    S_WAIT_I = 3'd3,
    S_RD_J   = 3'd4,
    S_WAIT_J = 3'd5,
    S_WR_I   = 3'd6,
    S_WR_J   = 3'd7
  } state_t;

  // Last value of the hold counter: the read is complete in the RD_LAT-th
  // hold cycle after the address cycle.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
  // Last key-byte index; kb wraps by compare so no modulo/divider is needed.
  localparam logic [4:0] KB_LAST   = 5'(KEY_BYTES - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;       // iteration index, doubles as fill index k
  logic [7:0]             j_q, j_d;
  logic [4:0]             kb_q, kb_d;     // key byte index, 0..KEY_BYTES-1
  logic [1:0]             wcnt_q, wcnt_d; // read hold counter
  logic [7:0]             si_q, si_d;     // S[i] as read this iteration
  logic [8*KEY_BYTES-1:0] key_q, key_d;   // key latched at start

  logic [7:0]             addr_q, addr_d;
  logic [7:0]             wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic                   rdy_q, rdy_d;
  logic                   done_q, done_d;

  logic [7:0]             j_new;

  // ---------------------------------------------------------------------------
  // Key byte lookup. The array is padded to 32 entries so the 5-bit kb
  // index covers it exactly for every legal KEY_BYTES; unused entries are
  // never selected because kb wraps at KEY_BYTES-1.
  // ---------------------------------------------------------------------------
  logic [7:0] key_arr [32];

  for (genvar b = 0; b < 32; b++) begin : g_key
    if (b < KEY_BYTES) begin : g_used
      assign key_arr[b] = key_q[8*(KEY_BYTES-1-b) +: 8];
    end else begin : g_pad
      assign key_arr[b] = 8'h00;
    end
  end

  // New j uses the S[i] byte arriving on rddata this cycle (8-bit wrap).
  assign j_new = j_q + rddata + key_arr[kb_q];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    kb_d     = kb_q;
    wcnt_d   = wcnt_q;
    si_d     = si_q;
    key_d    = key_q;
    addr_d   = 8'h00;
    wrdata_d = 8'h00;
    wren_d   = 1'b0;
    rdy_d    = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rdy_q gates acceptance so the cycle just after reset (rdy=0)
        // cannot start a run.
        if (rdy_q && en) begin
          key_d  = key;
          i_d    = 8'h00;
          j_d    = 8'h00;
          kb_d   = 5'd0;
          wcnt_d = 2'd0;
          if (fill) begin
            state_d = S_FILL;
            wren_d  = 1'b1;   // first fill write: S[0] = 0
          end else begin
            state_d = S_RD_I; // addr = i = 0
          end
        end else begin
          rdy_d = 1'b1;
        end
      end

      S_FILL: begin
        // i_q is the fill index; it wraps 255 -> 0, leaving i = 0 for the KSA.
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = S_RD_I;
        end else begin
          addr_d   = i_q + 8'd1;
          wrdata_d = i_q + 8'd1;
          wren_d   = 1'b1;
        end
      end

      S_RD_I: begin
        addr_d  = i_q;
        wcnt_d  = 2'd0;
        state_d = S_WAIT_I;
      end

      S_WAIT_I: begin
        if (wcnt_q == WAIT_LAST) begin
          si_d    = rddata;
          j_d     = j_new;
          addr_d  = j_new;
          state_d = S_RD_J;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
          addr_d = i_q;
        end
      end

      S_RD_J: begin
        addr_d  = j_q;
        wcnt_d  = 2'd0;
        state_d = S_WAIT_J;
      end

      S_WAIT_J: begin
        if (wcnt_q == WAIT_LAST) begin
          // rddata is S[j]; it goes straight out as the S[i] write data.
          addr_d   = i_q;
          wrdata_d = rddata;
          wren_d   = 1'b1;
          state_d  = S_WR_I;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
          addr_d = j_q;
        end
      end

      S_WR_I: begin
        // When i == j this rewrites the same address with the original
        // S[i], so the location ends up unchanged.
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
        state_d  = S_WR_J;
      end

      S_WR_J: begin
        i_d  = i_q + 8'd1;
        kb_d = (kb_q == KB_LAST) ? 5'd0 : kb_q + 5'd1;
        if (i_q == 8'hFF) begin
          // Iteration 255 complete; first idle cycle carries done.
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          addr_d  = i_q + 8'd1;
          state_d = S_RD_I;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= 8'h00;
      j_q      <= 8'h00;
      kb_q     <= 5'd0;
      wcnt_q   <= 2'd0;
      si_q     <= 8'h00;
      key_q    <= '0;
      addr_q   <= 8'h00;
      wrdata_q <= 8'h00;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kb_q     <= kb_d;
      wcnt_q   <= wcnt_d;
      si_q     <= si_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  assign addr    = addr_q;
  assign wrdata  = wrdata_q;
  assign wren    = wren_q;
  assign rdy     = rdy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ksa_param.sv
// -----------------------------------------------------------------------------
// tb_ksa_param -- self-checking bench for ksa_param
//
// Four engine instances with different KEY_BYTES / RD_LAT share clk and rst_n,
// each with its own S-memory model (RD_LAT-stage read pipeline). Before each
// run the bench computes the RC4 KSA in software, pushing every expected
// S-memory write {addr, data} onto exp_q and keeping the expected final
// contents; writes are popped and compared as the engine issues them.
// -----------------------------------------------------------------------------
module tb_ksa_param;

  localparam int NU = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        en_s       [NU];
  logic        fill_s     [NU];
  logic        rdy_s      [NU];
  logic        done_s     [NU];
  logic        wren_s     [NU];
  logic        preload_en [NU];
  logic [39:0] key_s      [NU];
  logic [7:0]  addr_s     [NU];
  logic [7:0]  rddata_s   [NU];
  logic [7:0]  wrdata_s   [NU];
  logic [2:0]  st_s       [NU];

  logic [7:0]  mem  [NU][256];
  logic [7:0]  pipe [NU][3];

  logic [15:0] exp_q[$];
  logic [7:0]  exp_final [256];

  int n_tests = 0;
  int n_fail  = 0;

  // unit 0: KEY_BYTES=3 RD_LAT=1 ; unit 1: 3/3 ; unit 2: 1/1 ; unit 3: 5/2
  ksa_param #(.KEY_BYTES(3), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .fill(fill_s[0]), .key(key_s[0][23:0]),
    .rdy(rdy_s[0]), .done(done_s[0]), .addr(addr_s[0]), .rddata(rddata_s[0]),
    .wrdata(wrdata_s[0]), .wren(wren_s[0]), .state_o(st_s[0]));

  ksa_param #(.KEY_BYTES(3), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .fill(fill_s[1]), .key(key_s[1][23:0]),
    .rdy(rdy_s[1]), .done(done_s[1]), .addr(addr_s[1]), .rddata(rddata_s[1]),
    .wrdata(wrdata_s[1]), .wren(wren_s[1]), .state_o(st_s[1]));

  ksa_param #(.KEY_BYTES(1), .RD_LAT(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_s[2]), .fill(fill_s[2]), .key(key_s[2][7:0]),
    .rdy(rdy_s[2]), .done(done_s[2]), .addr(addr_s[2]), .rddata(rddata_s[2]),
    .wrdata(wrdata_s[2]), .wren(wren_s[2]), .state_o(st_s[2]));

  ksa_param #(.KEY_BYTES(5), .RD_LAT(2)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .en(en_s[3]), .fill(fill_s[3]), .key(key_s[3][39:0]),
    .rdy(rdy_s[3]), .done(done_s[3]), .addr(addr_s[3]), .rddata(rddata_s[3]),
    .wrdata(wrdata_s[3]), .wren(wren_s[3]), .state_o(st_s[3]));

  // ---------------------------------------------------------------------------
  // S-memory models: address captured at the edge, data out RD_LAT-1 edges later
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (preload_en[u]) begin
        for (int a = 0; a < 256; a++) mem[u][a] <= 8'(a);
      end else if (wren_s[u]) begin
        mem[u][addr_s[u]] <= wrdata_s[u];
      end
      pipe[u][0] <= mem[u][addr_s[u]];
      pipe[u][1] <= pipe[u][0];
      pipe[u][2] <= pipe[u][1];
    end
  end

  assign rddata_s[0] = pipe[0][0];
  assign rddata_s[1] = pipe[1][2];
  assign rddata_s[2] = pipe[2][0];
  assign rddata_s[3] = pipe[3][1];

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Driver / scoreboard tasks
  // ---------------------------------------------------------------------------
  task automatic preload(input int u);
    preload_en[u] = 1'b1;
    @(negedge clk);
    preload_en[u] = 1'b0;
  endtask

  // Software RC4 KSA; fills exp_q with expected writes and exp_final.
  task automatic build_expect(input int u, input logic [39:0] k, input int klen,
                              input bit do_fill);
    logic [7:0] s [256];
    logic [7:0] j, t, kbyte;
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      if (do_fill) begin
        s[a] = 8'(a);
        exp_q.push_back({8'(a), 8'(a)});
      end else begin
        s[a] = mem[u][a];
      end
    end
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kbyte = 8'(k >> (8 * (klen - 1 - (i % klen))));
      j = j + s[i] + kbyte;
      exp_q.push_back({8'(i), s[j]});
      exp_q.push_back({j, s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int a = 0; a < 256; a++) exp_final[a] = s[a];
  endtask

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic start_run(input int u, input logic [39:0] k, input bit f, input bit hold);
    int w;
    w = 0;
    while (rdy_s[u] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (rdy_s[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_before_start: unit %0d rdy=%b expected 1", u, rdy_s[u]);
    end
    key_s[u]  = k;
    fill_s[u] = f;
    en_s[u]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) en_s[u] = 1'b0;
    n_tests++;
    if (rdy_s[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_after_accept: unit %0d rdy=%b expected 0", u, rdy_s[u]);
    end
  endtask

  // Follows a run from busy cycle 1, checking each write against exp_q.
  // Returns at the negedge of the done cycle, or of cycle stop_at.
  task automatic watch_run(input int u, input int stop_at, input int poke_at,
                           input logic [39:0] poke_key, output int busy,
                           output int first_wr, output bit got_done);
    int cyc;
    bit wr_bad;
    logic [15:0] e;
    cyc = 1; wr_bad = 1'b0; first_wr = 0; got_done = 1'b0; busy = 0;
    forever begin
      if (wren_s[u] === 1'b1) begin
        if (first_wr == 0) first_wr = cyc;
        if (!wr_bad) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++; wr_bad = 1'b1;
            $display("FAIL write_extra: unit %0d cycle %0d got addr=%0d data=%0d expected no write",
                     u, cyc, addr_s[u], wrdata_s[u]);
          end else begin
            e = exp_q.pop_front();
            if ({addr_s[u], wrdata_s[u]} !== e) begin
              n_fail++; wr_bad = 1'b1;
              $display("FAIL write_seq: unit %0d cycle %0d got addr=%0d data=%0d expected addr=%0d data=%0d",
                       u, cyc, addr_s[u], wrdata_s[u], e[15:8], e[7:0]);
            end
          end
        end
      end
      if (done_s[u] === 1'b1) begin
        got_done = 1'b1;
        busy = cyc - 1;
        break;
      end
      if (cyc == stop_at) break;
      if (poke_at > 0 && cyc == poke_at) begin
        key_s[u] = poke_key; en_s[u] = 1'b1; fill_s[u] = ~fill_s[u];
      end
      if (poke_at > 0 && cyc == poke_at + 2) begin
        en_s[u] = 1'b0; fill_s[u] = ~fill_s[u];
      end
      if (cyc > 6000) break;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic finish_checks(input int u, input string name, input int busy,
                               input int exp_busy, input bit got_done);
    int bad, first_bad;
    n_tests++;
    if (got_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_seen: unit %0d got no done within budget expected done", name, u);
    end
    n_tests++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s_busy: unit %0d got %0d cycles expected %0d", name, u, busy, exp_busy);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_writes_missing: unit %0d got %0d writes short expected 0", name, u, exp_q.size());
    end
    bad = 0; first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem[u][a] !== exp_final[a]) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s_final_mem: unit %0d got %0d wrong bytes (first S[%0d]=%0d) expected S[%0d]=%0d",
               name, u, bad, first_bad, mem[u][first_bad], first_bad, exp_final[first_bad]);
    end
    exp_q.delete();
  endtask

  task automatic check_single_done(input int u, input string name);
    @(negedge clk);
    n_tests++;
    if (done_s[u] !== 1'b0 || rdy_s[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after_done: unit %0d got done=%b rdy=%b expected done=0 rdy=1",
               name, u, done_s[u], rdy_s[u]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) begin
      en_s[u] = 1'b0; fill_s[u] = 1'b0; key_s[u] = '0; preload_en[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      n_tests++;
      if (rdy_s[u] !== 1'b0 || done_s[u] !== 1'b0 || wren_s[u] !== 1'b0 ||
          addr_s[u] !== 8'h00 || wrdata_s[u] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs: unit %0d got rdy=%b done=%b wren=%b addr=%0d wrdata=%0d expected all 0",
                 u, rdy_s[u], done_s[u], wren_s[u], addr_s[u], wrdata_s[u]);
      end
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        n_tests++;
        if (rdy_s[u] !== 1'b1 || done_s[u] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_release: unit %0d got rdy=%b done=%b expected rdy=1 done=0",
                   u, rdy_s[u], done_s[u]);
        end
      end
    end
  endtask

  task automatic test_fill_ksa();
    int busy, fw; bit gd;
    build_expect(0, 40'h1A2B3C, 3, 1'b1);
    start_run(0, 40'h1A2B3C, 1'b1, 1'b0);
    watch_run(0, 0, 0, '0, busy, fw, gd);
    finish_checks(0, "fill_ksa", busy, 1792, gd);
    n_tests++;
    if (fw !== 1) begin
      n_fail++;
      $display("FAIL fill_first_write: got cycle %0d expected 1", fw);
    end
    check_single_done(0, "fill_ksa");
  endtask

  task automatic test_lat3();
    int busy, fw; bit gd;
    preload(1);
    build_expect(1, 40'h000000, 3, 1'b0);
    start_run(1, 40'h000000, 1'b0, 1'b0);
    watch_run(1, 0, 0, '0, busy, fw, gd);
    finish_checks(1, "lat3", busy, 2560, gd);
    n_tests++;
    if (fw !== 9) begin
      n_fail++;
      $display("FAIL lat3_first_write: got cycle %0d expected 9", fw);
    end
    check_single_done(1, "lat3");
  endtask

  task automatic test_key1_same_ij();
    int busy, fw; bit gd;
    preload(2);
    build_expect(2, 40'h00, 1, 1'b0);
    start_run(2, 40'h00, 1'b0, 1'b0);
    watch_run(2, 0, 0, '0, busy, fw, gd);
    finish_checks(2, "key1", busy, 1536, gd);
    n_tests++;
    if (fw !== 5) begin
      n_fail++;
      $display("FAIL key1_first_write: got cycle %0d expected 5", fw);
    end
    check_single_done(2, "key1");
  endtask

  task automatic test_key5_busy_ignore();
    int busy, fw; bit gd;
    preload(3);
    build_expect(3, 40'h0102030405, 5, 1'b0);
    start_run(3, 40'h0102030405, 1'b0, 1'b0);
    watch_run(3, 0, 500, 40'hFFEEDDCCBB, busy, fw, gd);
    finish_checks(3, "key5", busy, 2048, gd);
    n_tests++;
    if (fw !== 7) begin
      n_fail++;
      $display("FAIL key5_first_write: got cycle %0d expected 7", fw);
    end
    check_single_done(3, "key5");
  endtask

  task automatic test_reset_mid_run();
    int busy, fw; bit gd;
    build_expect(0, 40'h123456, 3, 1'b0);
    start_run(0, 40'h123456, 1'b0, 1'b0);
    // busy cycle 605 is WR_I of iteration 100 (6 cycles per iteration)
    watch_run(0, 605, 0, '0, busy, fw, gd);
    n_tests++;
    if (wren_s[0] !== 1'b1 || gd !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre: got wren=%b done_seen=%b expected wren=1 done_seen=0", wren_s[0], gd);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wren_s[0] !== 1'b0 || st_s[0] !== 3'd0 || rdy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_in_reset: got wren=%b state=%0d rdy=%b done=%b expected 0 0 0 0",
               wren_s[0], st_s[0], rdy_s[0], done_s[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rdy_s[0] !== 1'b1 || wren_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: got rdy=%b wren=%b done=%b expected rdy=1 wren=0 done=0",
               rdy_s[0], wren_s[0], done_s[0]);
    end
    exp_q.delete();
    build_expect(0, 40'h123456, 3, 1'b1);
    start_run(0, 40'h123456, 1'b1, 1'b0);
    watch_run(0, 0, 0, '0, busy, fw, gd);
    finish_checks(0, "midrst_rerun", busy, 1792, gd);
    check_single_done(0, "midrst_rerun");
  endtask

  task automatic test_back_to_back();
    logic [39:0] keys [3];
    int busy, fw; bit gd;
    keys[0] = 40'hA5A5A5; keys[1] = 40'h0F1E2D; keys[2] = 40'hFFFFFF;
    build_expect(0, keys[0], 3, 1'b1);
    start_run(0, keys[0], 1'b1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      watch_run(0, 0, 0, '0, busy, fw, gd);
      finish_checks(0, "b2b", busy, 1792, gd);
      n_tests++;
      if (rdy_s[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_rdy_in_done: run %0d got rdy=%b expected 1", r, rdy_s[0]);
      end
      if (r < 2) begin
        build_expect(0, keys[r+1], 3, 1'b1);
        key_s[0] = keys[r+1];
        @(negedge clk);
        n_tests++;
        if (rdy_s[0] !== 1'b0 || wren_s[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart: run %0d got rdy=%b wren=%b expected rdy=0 wren=1",
                   r + 1, rdy_s[0], wren_s[0]);
        end
      end else begin
        en_s[0] = 1'b0;
      end
    end
    check_single_done(0, "b2b");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fill_ksa();
    test_lat3();
    test_key1_same_ij();
    test_key5_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
